// File: rtl/ps2_keystroke.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keystroke
// Purpose  : PS/2 keyboard receiver for the snake game. Deserialises 11-bit
//            device-to-host frames, checks start/parity/stop framing, tracks
//            E0/F0 prefixes and holds one level bit per game key.
// Ports    : clk        system clock
//            rst        synchronous active-high reset
//            ps2_clk    raw PS/2 clock pin (asynchronous)
//            ps2_data   raw PS/2 data pin (asynchronous)
//            keystroke  [0]W [1]S [2]A [3]D [4]Up [5]Down [6]Left [7]Right
//                       [8]Space [9]Esc
//            key_event  one-cycle pulse when keystroke changes
//            scan_code  last valid data byte
//            frame_err  one-cycle pulse on start/parity/stop/timeout error
// Revision : 1.0  initial release
// ============================================================================
module ps2_keystroke #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] keystroke,
    output logic       key_event,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int             c_TO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]     c_LAST_BIT = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: two-flop synchronisers, then a history filter
    // whose output only moves once FILTER_LEN samples agree.
    // ------------------------------------------------------------------
    logic                  r_clk_s1, r_clk_s2, r_data_s1, r_data_s2;
    logic [FILTER_LEN-1:0] r_clk_hist, r_data_hist;
    logic                  r_clk_filt, r_data_filt, r_clk_filt_d;
    logic                  w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_data_s1    <= 1'b1;
            r_data_s2    <= 1'b1;
            r_clk_hist   <= '1;
            r_data_hist  <= '1;
            r_clk_filt   <= 1'b1;
            r_data_filt  <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_data_s1    <= ps2_data;
            r_data_s2    <= r_data_s1;
            r_clk_hist   <= {r_clk_hist[FILTER_LEN-2:0], r_clk_s2};
            r_data_hist  <= {r_data_hist[FILTER_LEN-2:0], r_data_s2};
            if (&r_clk_hist)       r_clk_filt  <= 1'b1;
            else if (~|r_clk_hist) r_clk_filt  <= 1'b0;
            if (&r_data_hist)       r_data_filt <= 1'b1;
            else if (~|r_data_hist) r_data_filt <= 1'b0;
            r_clk_filt_d <= r_clk_filt;
        end
    end

    // Visible in the cycle after the filtered clock drops.
    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t              r_state, w_state_next;
    logic [3:0]          r_bit_cnt, w_bit_cnt_next;
    logic [9:0]          r_shift, w_shift_next;
    logic [c_TO_W-1:0]   r_to_cnt, w_to_cnt_next;
    logic                w_err;
    logic                w_byte_ok;

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_err          = 1'b0;
        w_byte_ok      = 1'b0;

        // Timeout counter only runs inside a frame and saturates at the limit.
        if (w_fall || (r_state != S_SHIFT))
            w_to_cnt_next = '0;
        else if (r_to_cnt != c_TO_MAX)
            w_to_cnt_next = r_to_cnt + 1'b1;
        else
            w_to_cnt_next = r_to_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    if (!r_data_filt) begin
                        w_state_next   = S_SHIFT;
                        w_bit_cnt_next = 4'd1;
                        w_shift_next   = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (w_fall) begin
                    // LSB-first: after ten shifts [7:0]=data, [8]=parity, [9]=stop.
                    w_shift_next   = {r_data_filt, r_shift[9:1]};
                    w_bit_cnt_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == c_LAST_BIT)
                        w_state_next = S_CHECK;
                end else if (r_to_cnt == c_TO_MAX) begin
                    w_err        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_CHECK: begin
                w_state_next = S_IDLE;
                if ((^r_shift[8:0]) && r_shift[9])
                    w_byte_ok = 1'b1;
                else
                    w_err = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    logic [7:0] r_byte;
    logic       r_byte_vld;
    logic       r_e0, r_f0, w_e0_next, w_f0_next;
    logic [9:0] r_keys, w_keys_next;
    logic       w_hit;
    logic [3:0] w_idx;

    always_comb begin
        w_hit = 1'b1;
        w_idx = 4'd0;
        case ({r_e0, r_byte})
            9'h01D:  w_idx = 4'd0;
            9'h01B:  w_idx = 4'd1;
            9'h01C:  w_idx = 4'd2;
            9'h023:  w_idx = 4'd3;
            9'h029:  w_idx = 4'd8;
            9'h076:  w_idx = 4'd9;
            9'h175:  w_idx = 4'd4;
            9'h172:  w_idx = 4'd5;
            9'h16B:  w_idx = 4'd6;
            9'h174:  w_idx = 4'd7;
            default: w_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_keys_next = r_keys;
        w_e0_next   = r_e0;
        w_f0_next   = r_f0;
        if (r_byte_vld) begin
            if (r_byte == 8'hE0) begin
                w_e0_next = 1'b1;
            end else if (r_byte == 8'hF0) begin
                w_f0_next = 1'b1;
            end else begin
                if (w_hit)
                    w_keys_next[w_idx] = ~r_f0;
                w_e0_next = 1'b0;
                w_f0_next = 1'b0;
            end
        end
        // A framing error loses the prefix sequence but keeps held keys.
        if (w_err) begin
            w_e0_next = 1'b0;
            w_f0_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= '0;
            r_to_cnt   <= '0;
            r_byte     <= 8'h00;
            r_byte_vld <= 1'b0;
            r_e0       <= 1'b0;
            r_f0       <= 1'b0;
            r_keys     <= '0;
            key_event  <= 1'b0;
            scan_code  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_to_cnt   <= w_to_cnt_next;
            r_byte_vld <= w_byte_ok;
            if (w_byte_ok) begin
                r_byte    <= r_shift[7:0];
                scan_code <= r_shift[7:0];
            end
            r_e0      <= w_e0_next;
            r_f0      <= w_f0_next;
            r_keys    <= w_keys_next;
            key_event <= (w_keys_next != r_keys);
            frame_err <= w_err;
        end
    end

    assign keystroke = r_keys;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keystroke.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keystroke
// Purpose  : Directed self-checking bench for ps2_keystroke.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_keystroke;

    localparam int HALF = 20;   // clk cycles per PS/2 half period

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] keystroke;
    logic       key_event;
    logic [7:0] scan_code;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int ev_cnt  = 0;
    int err_cnt = 0;
    int ev0, err0;

    ps2_keystroke #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keystroke (keystroke),
        .key_event (key_event),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_event === 1'b1) ev_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic good_parity);
        logic p;
        p = ~^d;
        if (!good_parity) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic glitch(input int n);
        ps2_clk = 1'b0;
        repeat (n) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_keys", keystroke, 10'h000);
        chk("reset_scan", scan_code, 8'h00);
        chk("reset_event", key_event, 1'b0);
        chk("reset_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // W make, then typematic repeat
        ev0 = ev_cnt; err0 = err_cnt;
        send_frame(8'h1D, 1'b1);
        chk("w_make_scan", scan_code, 8'h1D);
        chk("w_make_keys", keystroke, 10'h001);
        chk("w_make_events", ev_cnt - ev0, 1);
        chk("w_make_noerr", err_cnt - err0, 0);
        send_frame(8'h1D, 1'b1);
        chk("typematic_keys", keystroke, 10'h001);
        chk("typematic_events", ev_cnt - ev0, 1);

        // W break: F0 alone must not change the level
        send_frame(8'hF0, 1'b1);
        chk("f0_alone_keys", keystroke, 10'h001);
        chk("f0_scan", scan_code, 8'hF0);
        send_frame(8'h1D, 1'b1);
        chk("w_break_keys", keystroke, 10'h000);
        chk("w_events_total", ev_cnt - ev0, 2);

        // Extended arrows plus A
        ev0 = ev_cnt;
        send_frame(8'hE0, 1'b1); send_frame(8'h75, 1'b1);
        send_frame(8'hE0, 1'b1); send_frame(8'h6B, 1'b1);
        send_frame(8'h1C, 1'b1);
        chk("multi_keys", keystroke, 10'h054);
        chk("multi_events", ev_cnt - ev0, 3);
        ev0 = ev_cnt;
        send_frame(8'hE0, 1'b1); send_frame(8'hF0, 1'b1); send_frame(8'h75, 1'b1);
        chk("up_break_keys", keystroke, 10'h044);
        chk("up_break_events", ev_cnt - ev0, 1);

        // Bad parity frame, then a good Space make
        err0 = err_cnt; ev0 = ev_cnt;
        send_frame(8'h1D, 1'b0);
        chk("parity_err", err_cnt - err0, 1);
        chk("parity_keys", keystroke, 10'h044);
        chk("parity_scan", scan_code, 8'h75);
        chk("parity_events", ev_cnt - ev0, 0);
        send_frame(8'h29, 1'b1);
        chk("space_keys", keystroke, 10'h144);

        // Error drops a pending E0: following 75 is then unmatched
        err0 = err_cnt;
        send_frame(8'hE0, 1'b1);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h75, 1'b1);
        chk("e0_cleared_err", err_cnt - err0, 1);
        chk("e0_cleared_keys", keystroke, 10'h144);

        // Timeout mid-frame
        err0 = err_cnt;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (300) @(negedge clk);
        chk("timeout_err", err_cnt - err0, 1);
        chk("timeout_keys", keystroke, 10'h144);
        send_frame(8'h76, 1'b1);
        chk("esc_keys", keystroke, 10'h344);
        chk("esc_scan", scan_code, 8'h76);
        chk("timeout_err_total", err_cnt - err0, 1);

        // Short glitches on ps2_clk while data is low must not start a frame
        err0 = err_cnt;
        ps2_data = 1'b0;
        repeat (10) @(negedge clk);
        glitch(1); glitch(3); glitch(2);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h1B, 1'b1);
        chk("glitch_keys", keystroke, 10'h346);
        chk("glitch_scan", scan_code, 8'h1B);
        chk("glitch_noerr", err_cnt - err0, 0);

        // Reset in the middle of a frame
        err0 = err_cnt;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_keys", keystroke, 10'h000);
        chk("midrst_scan", scan_code, 8'h00);
        chk("midrst_event", key_event, 1'b0);
        rst = 1'b0;
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_noerr", err_cnt - err0, 0);
        send_frame(8'h1C, 1'b1);
        chk("post_rst_keys", keystroke, 10'h004);
        chk("post_rst_scan", scan_code, 8'h1C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
